// File: rtl/smpl_queue_if.sv
// Sample-in / window-out bundle between the audio front end and the stereo FIR.
// Holds the write strobe with its samples, and the sequenced output samples with their valid.
interface smpl_queue_if;
  logic signed [15:0] lft_smpl;
  logic signed [15:0] rght_smpl;
  logic               wrt_smpl;
  logic signed [15:0] lft_out;
  logic signed [15:0] rght_out;
  logic               sequencing;

  modport master (
    output lft_smpl, rght_smpl, wrt_smpl,
    input  lft_out, rght_out, sequencing
  );

  modport slave (
    input  lft_smpl, rght_smpl, wrt_smpl,
    output lft_out, rght_out, sequencing
  );
endinterface

// File: rtl/smpl_queue.sv
// Stereo sample history buffer. Once SEQ_LEN samples are held, each new write replays
// the newest SEQ_LEN samples, oldest first, one per cycle, into the FIR.
module smpl_queue #(
  parameter int DEPTH   = 1024,
  parameter int SEQ_LEN = 1021
) (
  input  logic         clk,
  input  logic         rst_n,
  smpl_queue_if.slave  bus
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int RD_CNT_W = PTR_W;

  typedef enum logic [1:0] {IDLE, PRIME, SEQ} state_t;

  state_t                state;
  logic [PTR_W-1:0]      new_ptr, old_ptr, rd_ptr;
  logic [PTR_W-1:0]      new_ptr_nxt, old_ptr_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [RD_CNT_W-1:0]   rd_cnt;
  logic                  pending;
  logic                  wr, cnt_full, win_ready, rd_en, rd_last, rd_vld;

  logic signed [15:0]    mem_l [DEPTH];
  logic signed [15:0]    mem_r [DEPTH];
  logic signed [15:0]    rd_l, rd_r;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr        = bus.wrt_smpl;
  assign cnt_full  = (cnt == CNT_W'(SEQ_LEN));
  assign win_ready = wr && (cnt_nxt == CNT_W'(SEQ_LEN));
  assign rd_en     = (state != IDLE);
  assign rd_last   = (rd_cnt == RD_CNT_W'(SEQ_LEN - 1));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    new_ptr_nxt = new_ptr;
    old_ptr_nxt = old_ptr;
    cnt_nxt     = cnt;
    if (wr) begin
      new_ptr_nxt = ptr_inc(new_ptr);
      if (cnt_full) old_ptr_nxt = ptr_inc(old_ptr);
      else          cnt_nxt     = cnt + 1'b1;
    end
  end

  // NOTE: storage and its read register carry no reset so they map onto block RAM;
  // cnt restarting at zero keeps stale contents out of any window.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_l[new_ptr] <= bus.lft_smpl;
      mem_r[new_ptr] <= bus.rght_smpl;
    end
    if (rd_en) begin
      rd_l <= mem_l[rd_ptr];
      rd_r <= mem_r[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      new_ptr        <= '0;
      old_ptr        <= '0;
      rd_ptr         <= '0;
      cnt            <= '0;
      rd_cnt         <= '0;
      pending        <= 1'b0;
      rd_vld         <= 1'b0;
      bus.sequencing <= 1'b0;
      bus.lft_out    <= '0;
      bus.rght_out   <= '0;
    end else begin
      new_ptr <= new_ptr_nxt;
      old_ptr <= old_ptr_nxt;
      cnt     <= cnt_nxt;

      // Read data lands one cycle after issue; outputs hold between windows.
      rd_vld         <= rd_en;
      bus.sequencing <= rd_vld;
      if (rd_vld) begin
        bus.lft_out  <= rd_l;
        bus.rght_out <= rd_r;
      end

      unique case (state)
        IDLE: begin
          if (win_ready) begin
            state  <= PRIME;
            rd_ptr <= old_ptr_nxt;
            rd_cnt <= '0;
          end
        end
        PRIME: begin
          rd_ptr <= ptr_inc(rd_ptr);
          rd_cnt <= rd_cnt + 1'b1;
          state  <= SEQ;
          if (wr) pending <= 1'b1;
        end
        SEQ: begin
          rd_ptr <= ptr_inc(rd_ptr);
          if (rd_last) begin
            rd_cnt <= '0;
            // A write on this final cycle still counts as a new trigger.
            if (pending || wr) begin
              state   <= PRIME;
              rd_ptr  <= old_ptr_nxt;
              pending <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
            if (wr) pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smpl_queue.sv
// Scoreboard bench for smpl_queue: a behavioural history model queues each expected
// window with the cycle every sample must appear on; a negedge monitor pops and compares.
module tb_smpl_queue;

  localparam int DEPTH = 1024;
  localparam int N     = 1021;

  typedef struct {
    logic signed [15:0] l;
    logic signed [15:0] r;
    int unsigned        cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  smpl_queue_if bus ();

  smpl_queue #(.DEPTH(DEPTH), .SEQ_LEN(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0]  hist [$];
  exp_t         exp_q [$];
  int unsigned  cyc = 0;
  int unsigned  end_edge = 0;
  bit           active = 0;
  bit           pending = 0;
  logic signed [15:0] last_l = '0, last_r = '0;

  task automatic start_win(input int unsigned s);
    exp_t e;
    for (int k = 0; k < hist.size(); k++) begin
      e.l   = hist[k][31:16];
      e.r   = hist[k][15:0];
      e.cyc = s + k;
      exp_q.push_back(e);
    end
    active   = 1;
    end_edge = s + N - 2;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      exp_q.delete();
      active  = 0;
      pending = 0;
    end else begin
      cyc++;
      if (bus.wrt_smpl) begin
        hist.push_back({bus.lft_smpl, bus.rght_smpl});
        if (hist.size() > N) void'(hist.pop_front());
      end
      if (active && cyc == end_edge) begin
        active = 0;
        if (pending || bus.wrt_smpl) begin
          pending = 0;
          start_win(cyc + 2);
        end
      end else if (active) begin
        if (bus.wrt_smpl) pending = 1;
      end else if (bus.wrt_smpl && hist.size() == N) begin
        start_win(cyc + 2);
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    bit   due;
    exp_t e;
    due = (exp_q.size() != 0) && (exp_q[0].cyc <= cyc);
    if (bus.sequencing === 1'b1 || due) begin
      check("sequencing", bus.sequencing, due);
      if (due) begin
        e = exp_q.pop_front();
        check("seq_cycle", cyc, e.cyc);
        if (bus.sequencing === 1'b1) begin
          check("lft_out", bus.lft_out, e.l);
          check("rght_out", bus.rght_out, e.r);
          last_l = e.l;
          last_r = e.r;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input int k);
    bus.wrt_smpl  = 1'b1;
    bus.lft_smpl  = 16'(k);
    bus.rght_smpl = 16'(-k);
    @(negedge clk);
    bus.wrt_smpl  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || active) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    idle(3);
    check("hold_l", bus.lft_out, last_l);
    check("hold_r", bus.rght_out, last_r);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned e0;
    bus.wrt_smpl  = 1'b0;
    bus.lft_smpl  = '0;
    bus.rght_smpl = '0;
    #3 rst_n = 1'b0;
    idle(3);
    check("rst_seq", bus.sequencing, 0);
    check("rst_lft", bus.lft_out, 0);
    check("rst_rght", bus.rght_out, 0);
    rst_n = 1'b1;
    idle(2);

    // Fill to one short of a window: nothing may be sequenced.
    for (int k = 1; k <= N - 1; k++) wr(k);
    idle(5);
    check("no_seq_1020", bus.sequencing, 0);
    check("no_win_1020", exp_q.size(), 0);

    // First full window 1..1021, then a single idle write giving 2..1022.
    wr(N);
    drain();
    wr(N + 1);
    drain();

    // Sparse writes (at most three per readout) walk the window across the pointer wrap.
    for (int k = N + 2; k <= 1100; k++) begin
      wr(k);
      idle(399);
    end
    drain();
    check("wrap_last", bus.lft_out, 1100);

    // Write mid-readout: first window untouched, second follows with no gap.
    pulse_reset();
    for (int k = 1; k <= N; k++) wr(k);
    idle(502);
    wr(N + 1);
    drain();

    // Write on the final SEQ cycle: back-to-back readout.
    wr(N + 2);
    e0 = cyc;
    while (cyc < e0 + N - 1) @(negedge clk);
    wr(N + 3);
    drain();

    // Reset in the middle of a readout, then a fresh window.
    wr(N + 4);
    idle(502);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_seq", bus.sequencing, 0);
    check("midrst_lft", bus.lft_out, 0);
    check("midrst_rght", bus.rght_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    for (int k = 2001; k <= 2000 + N - 1; k++) wr(k);
    idle(5);
    check("post_rst_no_seq", bus.sequencing, 0);
    wr(2000 + N);
    drain();
    check("post_rst_last", bus.rght_out, -(2000 + N));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/smpl_queue.md
SMPL_QUEUE -- requirements
Module: smpl_queue

Interface
REQ-001 Parameter DEPTH, default 1024, storage entries per channel.
REQ-002 Parameter SEQ_LEN, default 1021, samples per readout window (= FIR tap count); SHALL be < DEPTH.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 lft_smpl  input  16  signed left sample to store.
REQ-006 rght_smpl  input  16  signed right sample to store.
REQ-007 wrt_smpl  input  1  one-cycle strobe; store lft_smpl/rght_smpl.
REQ-008 lft_out  output  16  signed left sample to downstream FIR lft_in.
REQ-009 rght_out  output  16  signed right sample to downstream FIR rght_in.
REQ-010 sequencing  output  1  high while lft_out/rght_out carry a valid window sample; drives FIR sequencing.

Function
REQ-011 Storage SHALL be two DEPTH x 16 arrays with synchronous read: registered data, 1-cycle read latency.
REQ-012 On wrt_smpl, samples SHALL be written at new_ptr and new_ptr SHALL increment modulo DEPTH.
REQ-013 Counter cnt (11 bit) SHALL increment per write and saturate at SEQ_LEN.
REQ-014 On a write with cnt already == SEQ_LEN, old_ptr SHALL increment modulo DEPTH (oldest sample dropped); otherwise old_ptr holds.
REQ-015 States: IDLE, PRIME, SEQ; one-hot or binary at implementer's choice.
REQ-016 IDLE -> PRIME on the edge sampling a write that leaves cnt == SEQ_LEN; rd_ptr SHALL load the post-update old_ptr at that edge.
REQ-017 PRIME: read issued at rd_ptr, rd_ptr increments; -> SEQ next edge.
REQ-018 SEQ: sequencing = 1; one new sample per cycle, oldest first; rd_cnt (10 bit) counts 0..SEQ_LEN-1.
REQ-019 Readout SHALL stop issuing reads after SEQ_LEN reads; sequencing high exactly SEQ_LEN consecutive cycles, rising on the 2nd edge after the triggering write edge.
REQ-020 rd_ptr SHALL wrap DEPTH-1 -> 0; window contiguous across the wrap.
REQ-021 Writes during PRIME/SEQ SHALL be stored and update pointers per REQ-012..014 but SHALL NOT alter the active window; they set a pending flag.
REQ-022 At end of SEQ: pending set -> PRIME directly, window = current old_ptr, pending cleared; else -> IDLE.
REQ-023 Write coinciding with final SEQ cycle SHALL count as pending (no lost trigger).
REQ-024 More than DEPTH-SEQ_LEN writes during one readout is outside spec; no overflow detection required.
REQ-025 lft_out/rght_out SHALL hold last read value while sequencing = 0.
REQ-026 Left and right SHALL share all pointers; channels always aligned.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, sequencing 0, lft_out 0, rght_out 0, new_ptr 0, old_ptr 0, rd_ptr 0, cnt 0, rd_cnt 0, pending 0.
REQ-028 Memory contents need not reset; cnt = 0 guarantees stale data is never sequenced.
REQ-029 Reset mid-readout SHALL abort it; next readout requires SEQ_LEN fresh writes.

Verification
REQ-030 Reset -> sequencing 0, lft_out 0, rght_out 0; 1020 writes (lft = k, rght = -k, k = 1..1020) -> sequencing stays 0.
REQ-031 1021st write (k = 1021) -> sequencing rises 2 edges later, high 1021 cycles; lft_out 1..1021, rght_out -1..-1021, cycle-exact.
REQ-032 Write k = 1022 after idle -> window 2..1022; after 1100 total writes, window 80..1100, contiguous across pointer wrap at 1023 -> 0.
REQ-033 Write k = 1022 at SEQ cycle 500 of first readout -> first readout unchanged 1..1021; PRIME immediately after; second window 2..1022.
REQ-034 Write on final SEQ cycle -> new readout starts without IDLE gap; no trigger lost.
REQ-035 rst_n low at SEQ cycle 500 -> sequencing 0 same cycle; 1020 further writes -> no readout; 1021st -> readout of exactly those 1021 samples.
